// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, widths and helpers for the fetch stage
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry {instr, pc_plus4} buffer for a word fetched while decode is stalled
module fetch_hold_buffer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_consume,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc_plus4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc_plus4,
    output logic               o_valid
);

    logic [INSTR_W+PC_W-1:0] r_data;
    logic                    r_valid;

    // Clear wins over load so a redirect always discards a word captured the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= {i_instr, i_pc_plus4};
            r_valid <= 1'b1;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_instr    = r_data[INSTR_W+PC_W-1:PC_W];
    assign o_pc_plus4 = r_data[PC_W-1:0];
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage and IF/ID register; FETCH_PERF_CNT_EN adds bubble/flush counters
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hazard_stall,
    input  logic               mem_stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               icache_ren,
    output logic [29:0]        icache_addr,
    input  logic [INSTR_W-1:0] icache_rdata,
    input  logic               icache_stall,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_plus4,
    output logic               ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_bubble_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_target;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [PC_W-1:0]    r_ifid_pc_plus4;
    logic               r_ifid_valid;

    logic               w_advance;
    logic [PC_W-1:0]    w_pc_plus4;
    logic               w_word_ok;
    logic               w_hold_load;
    logic               w_hold_consume;
    logic [INSTR_W-1:0] w_hold_instr;
    logic [PC_W-1:0]    w_hold_pc_plus4;
    logic               w_hold_valid;

    assign w_advance      = !hazard_stall && !mem_stall;
    assign w_pc_plus4     = pc_inc(r_pc);
    assign w_word_ok      = (r_state == ST_RUN) && !icache_stall;
    assign w_hold_load    = !redirect_valid && w_word_ok && !w_advance;
    assign w_hold_consume = !redirect_valid && (r_state == ST_HOLD) && w_advance;

    fetch_hold_buffer u_hold (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_hold_load),
        .i_clear    (redirect_valid),
        .i_consume  (w_hold_consume),
        .i_instr    (icache_rdata),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (w_hold_instr),
        .o_pc_plus4 (w_hold_pc_plus4),
        .o_valid    (w_hold_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_RUN;
            r_pc            <= RESET_PC;
            r_target        <= RESET_PC;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= '0;
            r_ifid_valid    <= 1'b0;
        end else if (redirect_valid) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            // An outstanding miss pins icache_addr, so park the target until it drains.
            if (r_state != ST_HOLD && icache_stall) begin
                r_target <= redirect_pc;
                r_state  <= ST_DRAIN;
            end else begin
                r_pc    <= redirect_pc;
                r_state <= ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!icache_stall) begin
                        if (w_advance) begin
                            r_ifid_instr    <= icache_rdata;
                            r_ifid_pc_plus4 <= w_pc_plus4;
                            r_ifid_valid    <= 1'b1;
                            r_pc            <= w_pc_plus4;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end else if (w_advance) begin
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (w_advance) begin
                        r_ifid_instr    <= w_hold_instr;
                        r_ifid_pc_plus4 <= w_hold_pc_plus4;
                        r_ifid_valid    <= w_hold_valid;
                        r_pc            <= w_pc_plus4;
                        r_state         <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (w_advance) begin
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                    end
                    if (!icache_stall) begin
                        r_pc    <= r_target;
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign icache_ren    = (r_state != ST_HOLD) && !rst;
    assign icache_addr   = r_pc[31:2];
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign ifid_valid    = r_ifid_valid;

`ifdef FETCH_PERF_CNT_EN
    logic        w_bubble_fill;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    assign w_bubble_fill = !redirect_valid && w_advance &&
                           ((r_state == ST_RUN && icache_stall) || r_state == ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_bubble_fill && r_bubble_cnt != 32'hFFFF_FFFF)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (redirect_valid && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

`ifndef SYNTHESIS
    a_redirect_needs_advance: assert property (
        @(posedge clk) disable iff (rst) redirect_valid |-> w_advance
    );
`endif

endmodule
